rx_xfer_sched: RTL and testbench

- Sequences readout of all RX DDC channels into the shared double-banked RX sample BRAM, in the adc_clk domain.
- On each DDC sample-available strobe, it walks channels 0..RX_CHANS-1 and reads I then Q from each one.
- It generates BRAM write enables and addresses, and counts transfers per frame.
- It issues a single-cycle bank-flip strobe when a frame is complete. That strobe is then synchronised to cpu_clk, outside this block.
- It replaces the inline transfer logic in the receiver top level and adds overrun and overflow detection.

---
 rtl/rx_xfer_sched_pkg.sv | 23 ++
 rtl/rx_xfer_sched_if.sv | 28 ++
 rtl/rx_xfer_sched_wr_addr.sv | 59 +++++
 rtl/rx_xfer_sched.sv | 174 +++++++++++++++++
 tb/tb_rx_xfer_sched.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_xfer_sched_pkg.sv
// Shared definitions for the RX DDC-to-BRAM transfer scheduler:
// walk state encoding, default sizing and a select-width helper.
package rx_xfer_sched_pkg;

   localparam int RX_CHANS_DEF = 4;
   localparam int NSAMPS_W_DEF = 7;
   localparam int ADDR_W_DEF   = 10;

   // One channel walk: RD_I, RD_Q, GAP repeated per channel, then DONE.
   typedef enum logic [2:0] {
      RXS_IDLE = 3'd0,
      RXS_RD_I = 3'd1,
      RXS_RD_Q = 3'd2,
      RXS_GAP  = 3'd3,
      RXS_DONE = 3'd4
   } rx_state_t;

   // Width of the DDC channel select; a single channel still gets one bit.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rx_xfer_sched_if.sv
// DDC read strobes and BRAM port-A write bus driven by the scheduler.
// master = scheduler side, slave = DDC/BRAM/frame-consumer side.
interface rx_xfer_sched_if
   import rx_xfer_sched_pkg::*;
#(
   parameter int RX_CHANS = RX_CHANS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
);
   localparam int CHAN_W = chan_w(RX_CHANS);

   logic              rx_avail;   // new I/Q sample on every DDC
   logic              rd_i;       // select I word on every DDC output
   logic              rd_q;       // select Q word on every DDC output
   logic [CHAN_W-1:0] chan_sel;   // DDC output mux, aligned with the write
   logic              wr_en;      // BRAM port-A write enable
   logic [ADDR_W-1:0] waddr;      // BRAM port-A address within the bank
   logic              flip;       // end-of-frame bank swap strobe

   modport master (
      input  rx_avail,
      output rd_i, rd_q, chan_sel, wr_en, waddr, flip
   );

   modport slave (
      output rx_avail,
      input  rd_i, rd_q, chan_sel, wr_en, waddr, flip
   );
endinterface

// File: rtl/rx_xfer_sched_wr_addr.sv
// BRAM port-A address generator. Counts writes within the current bank,
// saturates at the last word and suppresses any write that would land on
// the last word a second time, flagging a sticky overflow instead.
module rx_xfer_sched_wr_addr #(
   parameter int ADDR_W = 10
) (
   input  logic              adc_clk,
   input  logic              reset_n,
   input  logic              wr_req,
   input  logic              flip,
   input  logic              clr_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] waddr,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

   logic [ADDR_W-1:0] waddr_reg;
   logic              top_written_reg;
   logic              overflow_reg;
   logic              at_top;
   logic              blocked;

   // The last word may be written once; a repeat attempt there is the
   // first word that no longer fits in the bank.
   assign at_top   = (waddr_reg == TOP_ADDR);
   assign blocked  = at_top && top_written_reg;
   assign wr_en    = wr_req && !blocked;
   assign waddr    = waddr_reg;
   assign overflow = overflow_reg;

   // Address advance per write, hold at the top, restart on bank flip.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr_reg       <= '0;
         top_written_reg <= 1'b0;
      end else if (flip) begin
         waddr_reg       <= '0;
         top_written_reg <= 1'b0;
      end else if (wr_en) begin
         if (at_top)
            top_written_reg <= 1'b1;
         else
            waddr_reg <= waddr_reg + 1'b1;
      end
   end

   // Sticky overflow flag; a new suppressed write beats a clear.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n)
         overflow_reg <= 1'b0;
      else if (wr_req && blocked)
         overflow_reg <= 1'b1;
      else if (clr_err)
         overflow_reg <= 1'b0;
   end

endmodule

// File: rtl/rx_xfer_sched.sv
// RX transfer scheduler: on each DDC sample strobe, walks every channel
// reading I then Q, writes the words into the current BRAM bank, counts
// walks per frame and emits a bank-flip strobe at frame end.
module rx_xfer_sched
   import rx_xfer_sched_pkg::*;
#(
   parameter int RX_CHANS = RX_CHANS_DEF,
   parameter int NSAMPS_W = NSAMPS_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic                adc_clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [NSAMPS_W-1:0] nsamps,
   input  logic                clr_err,
   output logic                busy,
   output logic                overrun,
   output logic                overflow,
   rx_xfer_sched_if.master     bus
);

   localparam int                CHAN_W    = chan_w(RX_CHANS);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(RX_CHANS - 1);

   rx_state_t           state_reg, state_next;
   logic [CHAN_W-1:0]   chan_reg, chan_next;
   logic [NSAMPS_W-1:0] count_reg, count_next;
   logic [NSAMPS_W-1:0] nsamps_q_reg;
   logic                nsamps_vld_reg;
   logic                frame_end;
   logic                flip_req_reg;
   logic                flip_reg;
   logic                rd_i;
   logic                rd_q;
   logic                wr_req_reg;
   logic [CHAN_W-1:0]   chan_sel_reg;
   logic                overrun_reg;
   logic                overrun_set;
   logic                wr_en;
   logic [ADDR_W-1:0]   waddr;

   // Any strobe outside IDLE (walking or in DONE) is a lost sample.
   assign overrun_set = bus.rx_avail && (state_reg != RXS_IDLE);

   // Walk state register with channel index and frame transfer count.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= RXS_IDLE;
         chan_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         chan_reg  <= chan_next;
         count_reg <= count_next;
      end
   end

   // Next-state, channel stepping, frame counting and read strobes.
   always_comb begin
      state_next = state_reg;
      chan_next  = chan_reg;
      count_next = count_reg;
      frame_end  = 1'b0;
      rd_i       = 1'b0;
      rd_q       = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         RXS_IDLE: begin
            if (bus.rx_avail && enable) begin
               state_next = RXS_RD_I;
               chan_next  = '0;
            end
         end
         RXS_RD_I: begin
            rd_i       = 1'b1;
            busy       = 1'b1;
            state_next = RXS_RD_Q;
         end
         RXS_RD_Q: begin
            rd_q       = 1'b1;
            busy       = 1'b1;
            state_next = RXS_GAP;
         end
         RXS_GAP: begin
            // Dead cycle while the DDC rotates its output register.
            busy = 1'b1;
            if (chan_reg == LAST_CHAN) begin
               state_next = RXS_DONE;
            end else begin
               chan_next  = chan_reg + 1'b1;
               state_next = RXS_RD_I;
            end
         end
         RXS_DONE: begin
            state_next = RXS_IDLE;
            if (count_reg == nsamps_q_reg) begin
               count_next = '0;
               frame_end  = 1'b1;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
         default: state_next = RXS_IDLE;
      endcase
   end

   // Frame length is sampled at the first strobe after reset and at every
   // flip, so a mid-frame change only affects the following frame.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         nsamps_q_reg   <= '0;
         nsamps_vld_reg <= 1'b0;
      end else if (flip_reg || (bus.rx_avail && !nsamps_vld_reg)) begin
         nsamps_q_reg   <= nsamps;
         nsamps_vld_reg <= 1'b1;
      end
   end

   // Frame-end decision is retimed twice before leaving as flip, keeping
   // the bank swap well clear of the final write of the walk.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         flip_req_reg <= 1'b0;
         flip_reg     <= 1'b0;
      end else begin
         flip_req_reg <= frame_end;
         flip_reg     <= flip_req_reg;
      end
   end

   // DDC output is registered: the write trails its read strobe by one
   // cycle, and the mux select trails the channel index to match.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_req_reg   <= 1'b0;
         chan_sel_reg <= '0;
      end else begin
         wr_req_reg   <= rd_i || rd_q;
         chan_sel_reg <= chan_reg;
      end
   end

   // Sticky overrun flag; a new lost strobe beats a clear.
   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n)
         overrun_reg <= 1'b0;
      else if (overrun_set)
         overrun_reg <= 1'b1;
      else if (clr_err)
         overrun_reg <= 1'b0;
   end

   rx_xfer_sched_wr_addr #(
      .ADDR_W (ADDR_W)
   ) u_wr_addr (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .wr_req   (wr_req_reg),
      .flip     (flip_reg),
      .clr_err  (clr_err),
      .wr_en    (wr_en),
      .waddr    (waddr),
      .overflow (overflow)
   );

   assign overrun      = overrun_reg;
   assign bus.rd_i     = rd_i;
   assign bus.rd_q     = rd_q;
   assign bus.chan_sel = chan_sel_reg;
   assign bus.wr_en    = wr_en;
   assign bus.waddr    = waddr;
   assign bus.flip     = flip_reg;

endmodule

// File: tb/tb_rx_xfer_sched.sv
// Scoreboard bench for rx_xfer_sched: each accepted rx_avail pushes the
// expected read strobes, writes and flip; a negedge monitor pops and
// compares them as the DUT produces them. A second instance with a
// 16-word bank exercises overflow.
`timescale 1ns/1ps
module tb_rx_xfer_sched;
   import rx_xfer_sched_pkg::*;

   localparam int RXC   = 4;
   localparam int NSW   = 7;
   localparam int AW    = 10;
   localparam int AW_OV = 4;

   typedef struct {
      int cyc;
      int chan;
      int addr;
      bit q;
   } wr_exp_t;

   logic           adc_clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           enable  = 1'b0;
   logic [NSW-1:0] nsamps    = '0;
   logic [NSW-1:0] nsamps_ov = 7'd2;
   logic           clr_err    = 1'b0;
   logic           clr_err_ov = 1'b0;
   logic           busy, overrun, overflow;
   logic           busy_ov, overrun_ov, overflow_ov;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard queues and reference model state
   wr_exp_t exp_wr[$];
   int      exp_rdi[$];
   int      exp_flip[$];
   wr_exp_t mon_e;
   int      m_count, m_nsq, m_addr, m_walk_end, m_latch_cyc;
   bit      m_nsq_vld, m_overrun;
   bit      prev_rdq = 1'b0;
   int      ov_wr_cnt = 0, ov_flip_cnt = 0, ov_flip_cyc = -1, ov_t = 0;

   rx_xfer_sched_if #(.RX_CHANS(RXC), .ADDR_W(AW))    bus ();
   rx_xfer_sched_if #(.RX_CHANS(RXC), .ADDR_W(AW_OV)) bus_ov ();

   rx_xfer_sched #(.RX_CHANS(RXC), .NSAMPS_W(NSW), .ADDR_W(AW)) dut (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .nsamps   (nsamps),
      .clr_err  (clr_err),
      .busy     (busy),
      .overrun  (overrun),
      .overflow (overflow),
      .bus      (bus)
   );

   rx_xfer_sched #(.RX_CHANS(RXC), .NSAMPS_W(NSW), .ADDR_W(AW_OV)) dut_ov (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .nsamps   (nsamps_ov),
      .clr_err  (clr_err_ov),
      .busy     (busy_ov),
      .overrun  (overrun_ov),
      .overflow (overflow_ov),
      .bus      (bus_ov)
   );

   always #5 adc_clk = ~adc_clk;
   always @(posedge adc_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] outs_main();
      return 32'({bus.rd_i, bus.rd_q, bus.wr_en, bus.flip, busy, overrun, overflow,
                  bus.chan_sel, bus.waddr});
   endfunction

   function automatic logic [31:0] outs_ov();
      return 32'({bus_ov.rd_i, bus_ov.rd_q, bus_ov.wr_en, bus_ov.flip, busy_ov,
                  overrun_ov, overflow_ov, bus_ov.chan_sel, bus_ov.waddr});
   endfunction

   task automatic model_reset();
      exp_wr.delete();
      exp_rdi.delete();
      exp_flip.delete();
      m_count     = 0;
      m_nsq       = 0;
      m_nsq_vld   = 1'b0;
      m_addr      = 0;
      m_walk_end  = -100;
      m_latch_cyc = -10;
      m_overrun   = 1'b0;
   endtask

   // Reference behaviour for an rx_avail strobe seen in cycle t.
   task automatic model_strobe(input int t, input bit clr);
      wr_exp_t e;
      if (!m_nsq_vld) begin
         m_nsq     = int'(nsamps);
         m_nsq_vld = 1'b1;
      end
      if (clr) m_overrun = 1'b0;
      if (t <= m_walk_end) begin
         m_overrun = 1'b1;
      end else if (enable) begin
         m_walk_end = t + 3*RXC + 1;
         for (int c = 0; c < RXC; c++) begin
            exp_rdi.push_back(t + 1 + 3*c);
            for (int k = 0; k < 2; k++) begin
               e.cyc  = t + 2 + 3*c + k;
               e.chan = c;
               e.addr = m_addr;
               e.q    = (k == 1);
               exp_wr.push_back(e);
               m_addr++;
            end
         end
         if (m_count == m_nsq) begin
            m_count     = 0;
            m_latch_cyc = t + 3*RXC + 3;
            exp_flip.push_back(m_latch_cyc);
            m_addr      = 0;
         end else begin
            m_count++;
         end
      end
   endtask

   task automatic step();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // One-cycle rx_avail on the main instance, optionally with clr_err.
   task automatic strobe(input bit clr);
      bus.rx_avail = 1'b1;
      clr_err      = clr;
      model_strobe(cyc, clr);
      step();
      bus.rx_avail = 1'b0;
      clr_err      = 1'b0;
   endtask

   // Negedge monitor: pops the scoreboard as DUT events appear.
   always @(negedge adc_clk) begin
      if (reset_n) begin
         if (bus.rd_i) begin
            chk("rdi_expected", 32'(exp_rdi.size() > 0), 32'd1);
            if (exp_rdi.size() > 0) chk("rdi_cycle", cyc, exp_rdi.pop_front());
         end
         if (bus.wr_en) begin
            chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) begin
               mon_e = exp_wr.pop_front();
               chk("wr_cycle", cyc, mon_e.cyc);
               chk("wr_chan_sel", 32'(bus.chan_sel), mon_e.chan);
               chk("wr_waddr", 32'(bus.waddr), mon_e.addr);
               chk("wr_iq", 32'(prev_rdq), 32'(mon_e.q));
               $display("wr cyc=%0d chan=%0d addr=%0d %s", cyc, bus.chan_sel, bus.waddr,
                        prev_rdq ? "Q" : "I");
            end
         end
         if (bus.flip) begin
            chk("flip_expected", 32'(exp_flip.size() > 0), 32'd1);
            if (exp_flip.size() > 0) chk("flip_cycle", cyc, exp_flip.pop_front());
            $display("flip cyc=%0d", cyc);
         end
         if (cyc == m_latch_cyc) m_nsq = int'(nsamps);
         if (cyc == m_latch_cyc + 1) chk("waddr_after_flip", 32'(bus.waddr), 32'd0);
         if (bus_ov.wr_en) ov_wr_cnt++;
         if (bus_ov.flip) begin
            ov_flip_cnt++;
            ov_flip_cyc = cyc;
         end
      end
      prev_rdq = bus.rd_q;
   end

   initial begin
      bus.rx_avail    = 1'b0;
      bus_ov.rx_avail = 1'b0;
      model_reset();
      #2 reset_n = 1'b0;
      repeat (3) @(posedge adc_clk);
      #1;
      chk("reset_outputs", outs_main(), 32'd0);
      reset_n = 1'b1;
      enable  = 1'b1;
      idle(3);

      // Basic walk, single-walk frames; nsamps=3 is taken at its flip
      nsamps = 7'd0;
      strobe(1'b0);
      nsamps = 7'd3;
      idle(20);

      // Four walks per frame
      for (int i = 0; i < 8; i++) begin
         strobe(1'b0);
         idle(19);
      end

      // Overrun: second strobe five cycles into a walk
      strobe(1'b0);
      idle(4);
      strobe(1'b0);
      idle(20);
      chk("overrun_set", 32'(overrun), 32'd1);
      chk("overrun_drained", exp_wr.size(), 32'd0);
      clr_err   = 1'b1;
      m_overrun = 1'b0;
      step();
      clr_err = 1'b0;
      chk("overrun_cleared", 32'(overrun), 32'd0);
      strobe(1'b0);
      idle(4);
      strobe(1'b1);
      idle(20);
      chk("overrun_set_wins", 32'(overrun), 32'd1);

      // Frame length change: old length holds until the next flip
      strobe(1'b0);
      idle(19);
      nsamps = 7'd1;
      strobe(1'b0);
      idle(19);
      strobe(1'b0);
      idle(5);
      nsamps = 7'd0;
      idle(14);
      strobe(1'b0);
      idle(19);
      strobe(1'b0);
      idle(19);

      // Enable dropped mid-walk: walk completes, later strobes ignored
      strobe(1'b0);
      idle(2);
      enable = 1'b0;
      idle(18);
      strobe(1'b0);
      idle(9);
      strobe(1'b0);
      idle(19);
      chk("disabled_drained", exp_wr.size(), 32'd0);
      chk("disabled_idle", 32'(busy), 32'd0);
      chk("disabled_no_overrun", 32'(overrun), 32'(m_overrun));
      enable = 1'b1;
      idle(2);

      // Overflow on the 16-word instance: 3 walks of 8 words
      for (int w = 0; w < 3; w++) begin
         bus_ov.rx_avail = 1'b1;
         ov_t = cyc;
         step();
         bus_ov.rx_avail = 1'b0;
         idle(19);
         if (w == 1) begin
            chk("ov_full_writes", ov_wr_cnt, 32'd16);
            chk("ov_flag_before", 32'(overflow_ov), 32'd0);
            chk("ov_no_flip_yet", ov_flip_cnt, 32'd0);
         end
      end
      chk("ov_writes_capped", ov_wr_cnt, 32'd16);
      chk("ov_flag", 32'(overflow_ov), 32'd1);
      chk("ov_flip_count", ov_flip_cnt, 32'd1);
      chk("ov_flip_cycle", ov_flip_cyc, ov_t + 3*RXC + 3);
      chk("ov_waddr_reset", 32'(bus_ov.waddr), 32'd0);

      // Asynchronous reset during RD_Q
      strobe(1'b0);
      idle(1);
      chk("pre_reset_rd_q", 32'(bus.rd_q), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_main", outs_main(), 32'd0);
      chk("async_reset_ov", outs_ov(), 32'd0);
      model_reset();
      idle(2);
      reset_n = 1'b1;
      idle(3);
      strobe(1'b0);
      idle(20);

      chk("end_wr_queue", exp_wr.size(), 32'd0);
      chk("end_rdi_queue", exp_rdi.size(), 32'd0);
      chk("end_flip_queue", exp_flip.size(), 32'd0);
      chk("end_overrun", 32'(overrun), 32'(m_overrun));
      chk("end_overflow", 32'(overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
